// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the bus datapath: bus source indices for the
// non-register sources, the number of those sources, and the memory FSM states.
package bus_datapath_pkg;

    // Non-register bus sources. A lower index means higher priority.
    // All of them rank below the general registers.
    localparam int SRC_HI       = 0;
    localparam int SRC_LO       = 1;
    localparam int SRC_ZHI      = 2;
    localparam int SRC_ZLO      = 3;
    localparam int SRC_PC       = 4;
    localparam int SRC_MDR      = 5;
    localparam int SRC_INPORT   = 6;
    localparam int SRC_IMM      = 7;
    localparam int NSRC_SPECIAL = 8;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_RD   = 2'd1,
        MEM_WR   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/bus_datapath_p_if.sv
// Memory handshake bundle between the datapath (master) and the memory (slave).
interface bus_datapath_p_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/bus_datapath_mem_ctrl.sv
// Memory transfer sequencer for the bus datapath.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   MEM_IDLE | no transfer; accepts mem_rd (priority) or mem_wr
//   MEM_RD   | read outstanding; mem_ack loads MDR and returns to idle
//   MEM_WR   | write outstanding; mem_ack returns to idle
module bus_datapath_mem_ctrl
    import bus_datapath_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic mem_rd,
    input  logic mem_wr,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic mem_busy,
    output logic mem_done,
    output logic rdata_load
);

    mem_state_t state_q;
    mem_state_t state_d;
    logic       done_d;

    // State register; mem_done is registered so it pulses the cycle after the ack edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= MEM_IDLE;
            mem_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_done <= done_d;
        end
    end

    // Next-state and handshake outputs; mem_ack in idle is simply not looked at.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_busy   = 1'b0;
        rdata_load = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_rd)      state_d = MEM_RD;
                else if (mem_wr) state_d = MEM_WR;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_busy = 1'b1;
                if (mem_ack) begin
                    rdata_load = 1'b1;
                    done_d     = 1'b1;
                    state_d    = MEM_IDLE;
                end
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_busy = 1'b1;
                if (mem_ack) begin
                    done_d  = 1'b1;
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

endmodule

// File: rtl/bus_datapath_p.sv
// Bus-oriented datapath: general registers, Y/Z/HI/LO/PC/MAR/MDR, I/O ports,
// a priority bus mux and a memory handshake through bus_datapath_mem_ctrl.
// Optional bus-conflict detector: define BUS_DATAPATH_CONFLICT_CHECK_EN.
module bus_datapath_p
    import bus_datapath_pkg::*;
#(
    parameter int              DATA_W = 32,
    parameter int              NREG   = 16,
    parameter int              ADDR_W = 9,
    parameter logic [DATA_W-1:0] PC_RST = '0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NREG-1:0]     reg_in,
    input  logic [NREG-1:0]     reg_out,
    input  logic                ba_out,
    input  logic                pc_in,
    input  logic                pc_out,
    input  logic                inc_pc,
    input  logic                y_in,
    input  logic                zlo_in,
    input  logic                zhi_in,
    input  logic                zlo_out,
    input  logic                zhi_out,
    input  logic                hi_in,
    input  logic                hi_out,
    input  logic                lo_in,
    input  logic                lo_out,
    input  logic                mdr_in,
    input  logic                mdr_out,
    input  logic                mar_in,
    input  logic                inport_out,
    input  logic                imm_out,
    input  logic                outport_in,
    input  logic [DATA_W-1:0]   imm_data,
    input  logic [DATA_W-1:0]   inport_data,
    input  logic                mem_rd,
    input  logic                mem_wr,
    bus_datapath_p_if.master    mem,
    output logic                mem_busy,
    output logic                mem_done,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [2*DATA_W-1:0] alu_c,
    output logic [DATA_W-1:0]   bus,
    output logic [DATA_W-1:0]   outport_data,
    output logic                bus_err
);

    localparam logic [DATA_W-1:0] ONE = 1;

    logic [DATA_W-1:0]       regs [NREG];
    logic [DATA_W-1:0]       y_q, hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, inport_q, outport_q;
    logic [ADDR_W-1:0]       mar_q;
    logic [DATA_W-1:0]       bus_v;
    logic [NSRC_SPECIAL-1:0] spec_out;
    logic [DATA_W-1:0]       spec_val [NSRC_SPECIAL];
    logic                    rdata_load;

    assign spec_out[SRC_HI]     = hi_out;
    assign spec_out[SRC_LO]     = lo_out;
    assign spec_out[SRC_ZHI]    = zhi_out;
    assign spec_out[SRC_ZLO]    = zlo_out;
    assign spec_out[SRC_PC]     = pc_out;
    assign spec_out[SRC_MDR]    = mdr_out;
    assign spec_out[SRC_INPORT] = inport_out;
    assign spec_out[SRC_IMM]    = imm_out;

    // Values of the non-register sources, indexed like spec_out.
    always_comb begin
        spec_val[SRC_HI]     = hi_q;
        spec_val[SRC_LO]     = lo_q;
        spec_val[SRC_ZHI]    = zhi_q;
        spec_val[SRC_ZLO]    = zlo_q;
        spec_val[SRC_PC]     = pc_q;
        spec_val[SRC_MDR]    = mdr_q;
        spec_val[SRC_INPORT] = inport_q;
        spec_val[SRC_IMM]    = imm_data;
    end

    // Priority bus mux: scan lowest priority first so higher ones override; R0 reads as 0 with ba_out.
    always_comb begin
        bus_v = '0;
        for (int i = NSRC_SPECIAL - 1; i >= 0; i--)
            if (spec_out[i]) bus_v = spec_val[i];
        for (int i = NREG - 1; i >= 0; i--)
            if (reg_out[i]) bus_v = regs[i];
        if (reg_out[0] && ba_out) bus_v = '0;
    end

    // General register file; several registers may load from the bus in one cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (reg_in[i]) regs[i] <= bus_v;
        end
    end

    // Special registers; MAR/MDR bus loads are blocked while a transfer is outstanding.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            y_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            pc_q      <= PC_RST;
            mdr_q     <= '0;
            mar_q     <= '0;
            inport_q  <= '0;
            outport_q <= '0;
        end else begin
            inport_q <= inport_data;
            if (y_in)       y_q       <= bus_v;
            if (hi_in)      hi_q      <= bus_v;
            if (lo_in)      lo_q      <= bus_v;
            if (outport_in) outport_q <= bus_v;
            if (zhi_in)     zhi_q     <= alu_c[2*DATA_W-1:DATA_W];
            if (zlo_in)     zlo_q     <= alu_c[DATA_W-1:0];
            if (pc_in)       pc_q <= bus_v;
            else if (inc_pc) pc_q <= pc_q + ONE;
            if (rdata_load)                mdr_q <= mem.mem_rdata;
            else if (mdr_in && !mem_busy)  mdr_q <= bus_v;
            if (mar_in && !mem_busy)       mar_q <= bus_v[ADDR_W-1:0];
        end
    end

    bus_datapath_mem_ctrl u_mem_ctrl (
        .clk        (clk),
        .clr        (clr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_ack    (mem.mem_ack),
        .mem_req    (mem.mem_req),
        .mem_we     (mem.mem_we),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .rdata_load (rdata_load)
    );

    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;
    assign bus           = bus_v;
    assign alu_a         = y_q;
    assign alu_b         = bus_v;
    assign outport_data  = outport_q;

`ifdef BUS_DATAPATH_CONFLICT_CHECK_EN
    localparam int NSRC = NREG + NSRC_SPECIAL;
    localparam logic [NSRC-1:0] SRC_ONE = 1;

    logic [NSRC-1:0] src_vec;
    logic            multi_src;

    assign src_vec   = {spec_out, reg_out};
    assign multi_src = (src_vec & (src_vec - SRC_ONE)) != '0;

    // Sticky conflict flag: set on the edge after any multi-driver cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) bus_err <= 1'b0;
        else     bus_err <= bus_err | multi_src;
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_datapath_p.sv
// Directed testbench for bus_datapath_p with hand-computed expectations.
module tb_bus_datapath_p;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] reg_in = '0, reg_out = '0;
    logic        ba_out = 0, pc_in = 0, pc_out = 0, inc_pc = 0, y_in = 0;
    logic        zlo_in = 0, zhi_in = 0, zlo_out = 0, zhi_out = 0;
    logic        hi_in = 0, hi_out = 0, lo_in = 0, lo_out = 0;
    logic        mdr_in = 0, mdr_out = 0, mar_in = 0, inport_out = 0, imm_out = 0, outport_in = 0;
    logic [31:0] imm_data = '0, inport_data = '0;
    logic        mem_rd = 0, mem_wr = 0;
    logic        mem_busy, mem_done, bus_err;
    logic [31:0] alu_a, alu_b, bus, outport_data;
    logic [63:0] alu_c = '0;

    int n_checks = 0;
    int n_errors = 0;
    int req_cycles;
    logic exp_err;

    bus_datapath_p_if #(.DATA_W(32), .ADDR_W(9)) mem_if ();

    bus_datapath_p #(.DATA_W(32), .NREG(16), .ADDR_W(9), .PC_RST(32'h0)) dut (
        .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out), .ba_out(ba_out),
        .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc), .y_in(y_in),
        .zlo_in(zlo_in), .zhi_in(zhi_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .mar_in(mar_in), .inport_out(inport_out),
        .imm_out(imm_out), .outport_in(outport_in), .imm_data(imm_data),
        .inport_data(inport_data), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem(mem_if),
        .mem_busy(mem_busy), .mem_done(mem_done), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .bus(bus), .outport_data(outport_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_strobes();
        reg_in = '0; reg_out = '0; ba_out = 0; pc_in = 0; pc_out = 0; inc_pc = 0;
        y_in = 0; zlo_in = 0; zhi_in = 0; zlo_out = 0; zhi_out = 0;
        hi_in = 0; hi_out = 0; lo_in = 0; lo_out = 0; mdr_in = 0; mdr_out = 0;
        mar_in = 0; inport_out = 0; imm_out = 0; outport_in = 0; mem_rd = 0; mem_wr = 0;
    endtask

    task automatic load_regs(input logic [31:0] v, input logic [15:0] sel);
        imm_data = v; imm_out = 1; reg_in = sel;
        tick();
        imm_out = 0; reg_in = '0;
    endtask

    task automatic pulse_clr();
        clr = 1; #2; clr = 0; #1;
    endtask

    initial begin
        mem_if.mem_ack = 0;
        mem_if.mem_rdata = '0;
`ifdef BUS_DATAPATH_CONFLICT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        #1 clr = 1;
        #1;
        chk("rst_bus", bus, 0);
        chk("rst_req", mem_if.mem_req, 0);
        chk("rst_we", mem_if.mem_we, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_done", mem_done, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_outport", outport_data, 0);
        chk("rst_y", alu_a, 0);
        pc_out = 1; #1; chk("rst_pc", bus, 0); pc_out = 0;
        mdr_out = 1; #1; chk("rst_mdr", bus, 0); mdr_out = 0;
        clr = 0;
        tick();

        // R3 load and drive
        load_regs(32'h0000_00AB, 16'h0008);
        reg_out = 16'h0008; #1;
        chk("r3_drive", bus, 32'h0000_00AB);
        chk("alu_b_is_bus", alu_b, 32'h0000_00AB);
        reg_out = '0;

        // ba_out forces R0 to zero
        load_regs(32'h0000_1234, 16'h0001);
        reg_out = 16'h0001; ba_out = 1; #1;
        chk("ba_out_zero", bus, 0);
        ba_out = 0; #1;
        chk("r0_drive", bus, 32'h0000_1234);
        tick();
        drop_strobes();
        chk("single_src_no_err", bus_err, 0);

        // simultaneous loads
        imm_data = 32'h55; imm_out = 1; reg_in = 16'h0060; y_in = 1; hi_in = 1; outport_in = 1;
        tick();
        drop_strobes();
        reg_out = 16'h0020; #1; chk("multi_r5", bus, 32'h55);
        reg_out = 16'h0040; #1; chk("multi_r6", bus, 32'h55);
        reg_out = '0; hi_out = 1; #1; chk("multi_hi", bus, 32'h55);
        hi_out = 0;
        chk("multi_y", alu_a, 32'h55);
        chk("multi_outport", outport_data, 32'h55);
        imm_data = 32'h77; imm_out = 1; lo_in = 1; tick(); drop_strobes();
        lo_out = 1; #1; chk("lo_drive", bus, 32'h77); lo_out = 0;

        // priority: R3 beats imm, HI beats LO
        reg_out = 16'h0008; imm_out = 1; imm_data = 32'h9; #1;
        chk("prio_reg_over_imm", bus, 32'hAB);
        drop_strobes();
        hi_out = 1; lo_out = 1; #1;
        chk("prio_hi_over_lo", bus, 32'h55);
        drop_strobes();

        // Z halves from alu_c
        alu_c = 64'h1111_2222_3333_4444; zhi_in = 1; zlo_in = 1;
        tick(); drop_strobes();
        zhi_out = 1; #1; chk("zhi", bus, 32'h1111_2222); zhi_out = 0;
        zlo_out = 1; #1; chk("zlo", bus, 32'h3333_4444); zlo_out = 0;

        // inport one-cycle latency
        inport_data = 32'hCAFE; inport_out = 1; #1;
        chk("inport_old", bus, 0);
        tick();
        chk("inport_new", bus, 32'hCAFE);
        drop_strobes();

        // PC wrap and pc_in priority
        imm_data = 32'hFFFF_FFFF; imm_out = 1; pc_in = 1; tick(); drop_strobes();
        pc_out = 1; #1; chk("pc_load", bus, 32'hFFFF_FFFF); pc_out = 0;
        inc_pc = 1; tick(); drop_strobes();
        pc_out = 1; #1; chk("pc_wrap", bus, 0); pc_out = 0;
        imm_data = 32'h40; imm_out = 1; pc_in = 1; inc_pc = 1; tick(); drop_strobes();
        pc_out = 1; #1; chk("pc_in_wins", bus, 32'h40); pc_out = 0;
        inc_pc = 1; tick(); drop_strobes();
        pc_out = 1; #1; chk("pc_inc", bus, 32'h41); pc_out = 0;

        // memory read with ack in the third request cycle
        imm_data = 32'h05; imm_out = 1; mar_in = 1; tick(); drop_strobes();
        mem_rd = 1; mem_wr = 1; tick(); drop_strobes();
        chk("rd_req", mem_if.mem_req, 1);
        chk("rd_we", mem_if.mem_we, 0);
        chk("rd_busy", mem_busy, 1);
        chk("rd_addr", mem_if.mem_addr, 9'h005);
        req_cycles = 0;
        for (int c = 1; c <= 3; c++) begin
            if (mem_if.mem_req) req_cycles++;
            if (c == 2) begin
                imm_data = 32'h1FF; imm_out = 1; mar_in = 1;
            end
            if (c == 3) begin
                mem_if.mem_ack = 1; mem_if.mem_rdata = 32'hDEAD_BEEF;
                imm_data = 32'h1357; imm_out = 1; mdr_in = 1;
            end
            tick();
            drop_strobes();
        end
        mem_if.mem_ack = 0;
        chk("rd_req_cycles", req_cycles, 3);
        chk("rd_req_low", mem_if.mem_req, 0);
        chk("rd_done", mem_done, 1);
        chk("rd_mar_held", mem_if.mem_addr, 9'h005);
        mdr_out = 1; #1; chk("rd_mdr", bus, 32'hDEAD_BEEF); mdr_out = 0;
        tick();
        chk("rd_done_once", mem_done, 0);

        // memory write
        imm_data = 32'h1234_5678; imm_out = 1; mdr_in = 1; tick(); drop_strobes();
        mem_wr = 1; tick(); drop_strobes();
        chk("wr_req", mem_if.mem_req, 1);
        chk("wr_we", mem_if.mem_we, 1);
        chk("wr_wdata", mem_if.mem_wdata, 32'h1234_5678);
        mem_rd = 1; tick(); mem_rd = 0;
        chk("wr_ignores_rd", mem_if.mem_we, 1);
        mem_if.mem_ack = 1; tick(); mem_if.mem_ack = 0;
        chk("wr_done", mem_done, 1);
        chk("wr_idle", mem_busy, 0);
        tick();

        // ack while idle is ignored
        mem_if.mem_ack = 1; mem_if.mem_rdata = 32'hAAAA_5555; tick(); mem_if.mem_ack = 0;
        chk("idle_ack_done", mem_done, 0);
        chk("idle_ack_req", mem_if.mem_req, 0);
        mdr_out = 1; #1; chk("idle_ack_mdr", bus, 32'h1234_5678); mdr_out = 0;

        // clr in the middle of a read abandons it
        mem_rd = 1; tick(); mem_rd = 0;
        chk("abort_busy_pre", mem_busy, 1);
        pulse_clr();
        chk("abort_req", mem_if.mem_req, 0);
        chk("abort_busy", mem_busy, 0);
        mem_if.mem_ack = 1; mem_if.mem_rdata = 32'h0BAD_F00D; tick(); mem_if.mem_ack = 0;
        chk("abort_no_done", mem_done, 0);
        mdr_out = 1; #1; chk("abort_mdr", bus, 0); mdr_out = 0;
        tick();
        chk("abort_no_done2", mem_done, 0);

        // bus conflict
        load_regs(32'h0000_0099, 16'h0002);
        reg_out = 16'h0002; pc_out = 1; #1;
        chk("conflict_bus", bus, 32'h99);
        chk("conflict_err_pre", bus_err, 0);
        tick(); drop_strobes();
        chk("conflict_err", bus_err, exp_err);
        tick();
        chk("conflict_err_held", bus_err, exp_err);
        pulse_clr();
        chk("conflict_err_clr", bus_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
